// File: rtl/nexys_starship_spawn_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nexys_starship_spawn_gen : shared timer_clk divider plus LFSR-driven
// per-terminal spawn pulses whose odds ramp with a difficulty level.
// Optional macro: SPAWN_SEED_SWITCH_EN (seed from seed_sw at game start).
// Revision: 1.0
// ---------------------------------------------------------------------------
module nexys_starship_spawn_gen #(
  parameter int          CLK_HZ      = 100_000_000,
  parameter int          TICK_HZ     = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          NUM_TERM    = 4,
  parameter int          LEVEL_TICKS = 20,
  parameter int          MAX_LEVEL   = 7
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                play_flag,
  input  logic                gameover_ctrl,
  input  logic [15:0]         seed_sw,
  output logic                timer_clk,
  output logic                timer_tick,
  output logic [NUM_TERM-1:0] term_random,
  output logic [3:0]          level,
  output logic                q_Idle,
  output logic                q_Run,
  output logic                q_Over
);

  localparam int              HALF       = CLK_HZ / (2 * TICK_HZ);
  localparam int              CW         = $clog2(HALF);
  localparam int              TW         = (LEVEL_TICKS > 1) ? $clog2(LEVEL_TICKS) : 1;
  localparam logic [CW-1:0]   CNT_LAST   = CW'(HALF - 1);
  localparam logic [TW-1:0]   TCNT_LAST  = TW'(LEVEL_TICKS - 1);
  localparam logic [3:0]      LEVEL_MAX  = 4'(MAX_LEVEL);
  localparam logic [15:0]     LFSR_MASK  = 16'hB400;

  localparam logic [2:0]      ST_IDLE    = 3'b001;
  localparam logic [2:0]      ST_RUN     = 3'b010;
  localparam logic [2:0]      ST_OVER    = 3'b100;

  logic [CW-1:0]       cnt;
  logic [TW-1:0]       tick_cnt;
  logic [15:0]         lfsr;
  logic [15:0]         lfsr_next;
  logic [15:0]         seed;
  logic [2:0]          state;
  logic [2:0]          state_next;
  logic [NUM_TERM-1:0] spawn_hit;
  logic                div_wrap;

`ifdef SPAWN_SEED_SWITCH_EN
  // An all-zero switch setting would lock the LFSR, so fall back to the default.
  assign seed = (seed_sw == 16'h0000) ? LFSR_SEED : seed_sw;
`else
  logic unused_seed_sw;
  assign seed           = LFSR_SEED;
  assign unused_seed_sw = ^seed_sw;
`endif

  assign div_wrap  = (cnt == CNT_LAST);
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);

  for (genvar i = 0; i < NUM_TERM; i++) begin : g_term
    assign spawn_hit[i] = (lfsr[4*i +: 4] <= level);
  end

  assign q_Idle = state[0];
  assign q_Run  = state[1];
  assign q_Over = state[2];

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (play_flag)      state_next = ST_RUN;
      ST_RUN:  if (gameover_ctrl)  state_next = ST_OVER;
      ST_OVER: if (!play_flag)     state_next = ST_IDLE;
      default:                     state_next = ST_IDLE;
    endcase
  end

  // The tick is registered alongside the new timer_clk value so both rise together.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt        <= '0;
      timer_clk  <= 1'b0;
      timer_tick <= 1'b0;
    end else if (div_wrap) begin
      cnt        <= '0;
      timer_clk  <= ~timer_clk;
      timer_tick <= ~timer_clk;
    end else begin
      cnt        <= cnt + 1'b1;
      timer_tick <= 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= ST_IDLE;
      lfsr        <= LFSR_SEED;
      level       <= 4'd0;
      tick_cnt    <= '0;
      term_random <= '0;
    end else begin
      state       <= state_next;
      term_random <= '0;
      case (state)
        ST_IDLE: begin
          level    <= 4'd0;
          tick_cnt <= '0;
          if (play_flag) lfsr <= seed;
        end
        ST_RUN: begin
          lfsr <= lfsr_next;
          // Game-over wins: no spawn and no level progress on that cycle.
          if (!gameover_ctrl && timer_tick) begin
            term_random <= spawn_hit;
            if (tick_cnt == TCNT_LAST) begin
              tick_cnt <= '0;
              if (level < LEVEL_MAX) level <= level + 4'd1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        ST_OVER: begin
          if (!play_flag) begin
            level    <= 4'd0;
            tick_cnt <= '0;
          end
        end
        default: begin
          level    <= 4'd0;
          tick_cnt <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nexys_starship_spawn_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_nexys_starship_spawn_gen : directed bench with a small LFSR/level model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_nexys_starship_spawn_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        play_flag = 1'b0;
  logic        gameover_ctrl = 1'b0;
  logic [15:0] seed_sw = 16'h0000;
  logic        timer_clk;
  logic        timer_tick;
  logic [3:0]  term_random;
  logic [3:0]  level;
  logic        q_Idle;
  logic        q_Run;
  logic        q_Over;

  int compared = 0;
  int mismatched = 0;
  int n = 0;
  int pulses = 0;

  logic        e_run = 1'b0;
  logic        e_enter = 1'b0;
  logic [15:0] e_lfsr = 16'h0;
  logic [15:0] e_seed = 16'h0;
  logic [3:0]  e_level = 4'd0;
  logic [3:0]  e_rand = 4'd0;
  int          e_ticks = 0;

  nexys_starship_spawn_gen #(
    .CLK_HZ(16), .TICK_HZ(2), .LFSR_SEED(16'hACE1),
    .NUM_TERM(4), .LEVEL_TICKS(3), .MAX_LEVEL(7)
  ) dut (
    .Clk(clk), .Reset(rst), .play_flag(play_flag), .gameover_ctrl(gameover_ctrl),
    .seed_sw(seed_sw), .timer_clk(timer_clk), .timer_tick(timer_tick),
    .term_random(term_random), .level(level),
    .q_Idle(q_Idle), .q_Run(q_Run), .q_Over(q_Over)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] model_next(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: model follows the posedge, returns at the following negedge.
  task automatic step();
    logic pt;
    @(posedge clk);
    pt = (n % 8 == 4);
    if (e_enter) begin
      e_enter = 1'b0;
      e_run   = 1'b1;
      e_lfsr  = e_seed;
      e_ticks = 0;
      e_level = 4'd0;
      e_rand  = 4'd0;
    end else if (e_run) begin
      e_rand = 4'd0;
      if (gameover_ctrl) begin
        e_run = 1'b0;
      end else begin
        if (pt) begin
          for (int i = 0; i < 4; i++)
            e_rand[i] = (((e_lfsr >> (4*i)) & 16'h000F) <= {12'h000, e_level});
          e_ticks++;
          e_level = (e_ticks / 3 > 7) ? 4'd7 : 4'(e_ticks / 3);
        end
        e_lfsr = model_next(e_lfsr);
      end
    end
    n++;
    @(negedge clk);
  endtask

  task automatic enter();
    play_flag = 1'b1;
    e_enter   = 1'b1;
`ifdef SPAWN_SEED_SWITCH_EN
    e_seed = (seed_sw == 16'h0000) ? 16'hACE1 : seed_sw;
`else
    e_seed = 16'hACE1;
`endif
    step();
    check("run_entry", q_Run, 1);
    check("seed_load", dut.lfsr, e_seed);
  endtask

  task automatic run_ticks(input int target);
    int t0;
    for (int k = 0; k < 2000 && e_ticks < target; k++) begin
      t0 = e_ticks;
      step();
      check("term_random", term_random, e_rand);
      check("level", level, e_level);
      check("q_Run_hold", q_Run, 1);
      if (term_random != 4'd0) pulses++;
      if (e_ticks != t0) begin
        case (e_ticks)
          2:  check("level_tick2", level, 0);
          3:  check("level_tick3", level, 1);
          21: check("level_tick21", level, 7);
          30: check("level_tick30", level, 7);
          default: ;
        endcase
      end
    end
    check("tick_budget", (e_ticks >= target) ? 1 : 0, 1);
  endtask

  initial begin
    logic found;
    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_timer_clk", timer_clk, 0);
    check("rst_tick", timer_tick, 0);
    check("rst_rand", term_random, 0);
    check("rst_level", level, 0);
    check("rst_q_Idle", q_Idle, 1);
    check("rst_q_Run", q_Run, 0);
    rst = 1'b0;
    n = 0;

    // Idle divider: toggle every 4 clocks, tick every 8
    for (int k = 0; k < 16; k++) begin
      step();
      check("idle_timer_clk", timer_clk, (n / 4) % 2);
      check("idle_tick", timer_tick, (n % 8 == 4) ? 1 : 0);
      check("idle_rand", term_random, 0);
      check("idle_q_Idle", q_Idle, 1);
    end
    check("idle_lfsr_hold", dut.lfsr, 16'hACE1);

    // Game 1: level ramp and bit-accurate spawn over 64 ticks
    seed_sw = 16'h5A5A;
    enter();
    run_ticks(64);
    check("pulses_seen", (pulses > 0) ? 1 : 0, 1);

    // Reset mid-RUN right on a live spawn pulse
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      step();
      check("pre_rst_rand", term_random, e_rand);
      if (term_random != 4'd0) begin
        found = 1'b1;
        break;
      end
    end
    check("pulse_before_reset", found, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_timer_clk", timer_clk, 0);
    check("mid_rst_tick", timer_tick, 0);
    check("mid_rst_rand", term_random, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_q_Idle", q_Idle, 1);
    check("mid_rst_q_Run", q_Run, 0);
    check("mid_rst_q_Over", q_Over, 0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    e_run = 1'b0;
    play_flag = 1'b0;

    // Game 2: play_flag drop ignored, game-over on a tick holds level
    enter();
    run_ticks(2);
    play_flag = 1'b0;
    run_ticks(4);
    play_flag = 1'b1;
    run_ticks(5);
    for (int k = 0; k < 16 && (n % 8 != 4); k++) begin
      step();
      check("wait_rand", term_random, e_rand);
    end
    check("tick_before_go", timer_tick, 1);
    gameover_ctrl = 1'b1;
    step();
    check("go_no_pulse", term_random, 0);
    check("go_q_Over", q_Over, 1);
    check("go_q_Run", q_Run, 0);
    check("go_level_held", level, 1);
    gameover_ctrl = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("over_q_Over", q_Over, 1);
      check("over_rand", term_random, 0);
      check("over_level", level, 1);
    end
    play_flag = 1'b0;
    step();
    check("exit_q_Idle", q_Idle, 1);
    check("exit_q_Over", q_Over, 0);
    check("exit_level", level, 0);

`ifdef SPAWN_SEED_SWITCH_EN
    seed_sw = 16'h0000;
    enter();
    check("seed_zero_sub", dut.lfsr, 16'hACE1);
    run_ticks(4);
    gameover_ctrl = 1'b1;
    step();
    gameover_ctrl = 1'b0;
    play_flag = 1'b0;
    step();
    seed_sw = 16'h1234;
    enter();
    check("seed_switch", dut.lfsr, 16'h1234);
    run_ticks(8);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
